bit_serial_alu_ctrl: RTL and testbench

Sequencer that runs one `bitSlice` instance as a WIDTH-bit bit-serial ALU. It accepts a full-width operation, feeds operand bits LSB-first through the slice, and carries `c_out` into the next bit's `c_in` through a flip-flop. The result is assembled in a shift register. It is the first sequential block above the 1-bit ALU datapath. It lets the 32-bit ALU be built from one slice instead of WIDTH slices.

---
 rtl/alu_pkg.sv | 14 +
 rtl/bitSlice.sv | 31 +++
 rtl/bit_serial_alu_ctrl.sv | 102 ++++++++++
 tb/tb_bit_serial_alu_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state constants for the bit-serial ALU.
// Opcode values match the bitSlice ALUop encoding.
package alu_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/bitSlice.sv
// 1-bit ALU slice, purely combinational, zero latency, no flow control.
// SUB inverts r3 internally; the caller supplies c_in = 1 on the LSB.
module bitSlice
   import alu_pkg::*;
(
   input  logic       r2,
   input  logic       r3,
   input  logic       c_in,
   input  logic [2:0] ALUop,
   output logic       r1,
   output logic       c_out
);

   logic w_b;

   always_comb begin
      w_b   = (ALUop == OP_SUB) ? ~r3 : r3;
      r1    = 1'b0;
      c_out = 1'b0;
      case (ALUop)
         OP_AND: r1 = r2 & r3;
         OP_OR:  r1 = r2 | r3;
         OP_ADD, OP_SUB: begin
            r1    = r2 ^ w_b ^ c_in;
            c_out = (r2 & w_b) | (c_in & (r2 ^ w_b));
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Runs one bitSlice LSB-first over WIDTH bits; done WIDTH+1 cycles after accept.
// No backpressure: start is only sampled in IDLE, requests while busy are dropped.
module bit_serial_alu_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             zero
);

   localparam int IDXW = $clog2(WIDTH);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [IDXW-1:0]  r_idx;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-2:0] r_res_sh;
   logic [2:0]       r_op;
   logic             r_carry;
   logic [WIDTH-1:0] r_result;
   logic             r_c_out;
   logic             r_zero;

   logic             w_r1;
   logic             w_c_out;
   logic [WIDTH-1:0] w_res_nxt;

   bitSlice u_slice (
      .r2    (r_a_sh[0]),
      .r3    (r_b_sh[0]),
      .c_in  (r_carry),
      .ALUop (r_op),
      .r1    (w_r1),
      .c_out (w_c_out)
   );

   // On the final step this is the complete result, bit WIDTH-1 just arriving.
   assign w_res_nxt = {w_r1, r_res_sh};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_res_sh <= '0;
         r_op     <= OP_AND;
         r_carry  <= 1'b0;
         r_result <= '0;
         r_c_out  <= 1'b0;
         r_zero   <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a_sh  <= a;
                  r_b_sh  <= b;
                  r_op    <= op;
                  r_idx   <= '0;
                  r_carry <= (op == OP_SUB);
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_res_sh <= w_res_nxt[WIDTH-1:1];
               r_carry  <= w_c_out;
               if (r_idx == LAST_IDX) begin
                  r_state  <= ST_DONE;
                  r_result <= w_res_nxt;
                  r_c_out  <= w_c_out;
                  r_zero   <= (w_res_nxt == '0);
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy   = (r_state != ST_IDLE);
   assign done   = (r_state == ST_DONE);
   assign result = r_result;
   assign c_out  = r_c_out;
   assign zero   = r_zero;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Bench for bit_serial_alu_ctrl at WIDTH=8: vector table plus reset/held-start sequences.
module tb_bit_serial_alu_ctrl;
   import alu_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         c_out;
   logic         zero;

   always #5 clk = ~clk;

   bit_serial_alu_ctrl #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .c_out  (c_out),
      .zero   (zero)
   );

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         c;
      logic         z;
   } vec_t;

   vec_t         tbl[7];
   vec_t         sb_q[$];
   int           n_vec = 0;
   int           n_err = 0;
   int           n_done = 0;
   int           cyc = 0;
   int           last_done_cyc = -1;
   bit           chk_gap = 1'b0;
   logic [W-1:0] last_res = '0;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural reference slice, chained W times by chain_v.
   function automatic logic [1:0] bitSlice_v(input logic x, input logic y, input logic ci,
                                             input logic [2:0] o);
      logic yy;
      yy = (o == OP_SUB) ? ~y : y;
      case (o)
         OP_AND:         return {1'b0, x & y};
         OP_OR:          return {1'b0, x | y};
         OP_ADD, OP_SUB: return {(x & yy) | (x & ci) | (yy & ci), x ^ yy ^ ci};
         default:        return 2'b00;
      endcase
   endfunction

   function automatic vec_t chain_v(input logic [2:0] o, input logic [W-1:0] x,
                                    input logic [W-1:0] y);
      vec_t       v;
      logic       c;
      logic [1:0] s;
      c     = (o == OP_SUB);
      v.op  = o;
      v.a   = x;
      v.b   = y;
      v.res = '0;
      for (int i = 0; i < W; i++) begin
         s        = bitSlice_v(x[i], y[i], c, o);
         v.res[i] = s[0];
         c        = s[1];
      end
      v.c = c;
      v.z = (v.res == '0);
      return v;
   endfunction

   task automatic handle_done();
      vec_t e;
      vec_t m;
      n_done++;
      if (sb_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL unexpected_done: done=1 with nothing outstanding, required 0 (cycle %0d)", cyc);
      end else begin
         e = sb_q.pop_front();
         m = chain_v(e.op, e.a, e.b);
         check("result", result, e.res);
         check("c_out", c_out, e.c);
         check("zero", zero, e.z);
         check("ref_result", result, m.res);
         check("ref_c_out", c_out, m.c);
         if (chk_gap && last_done_cyc >= 0)
            check("done_period", cyc - last_done_cyc, 10);
      end
      last_done_cyc = cyc;
   endtask

   // Every wait goes through here so done pulses are never missed.
   task automatic tick();
      @(negedge clk);
      if (done) handle_done();
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (busy && k < 40) begin
         tick();
         k++;
      end
      if (busy) check(name, busy, 0);
   endtask

   task automatic run_op(input vec_t v, input int glitch_cyc);
      int k;
      wait_idle("wait_idle");
      op    = v.op;
      a     = v.a;
      b     = v.b;
      start = 1'b1;
      sb_q.push_back(v);
      tick();
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      op    = 3'($urandom_range(7, 0));
      check("busy_rise", busy, 1);
      k = 1;
      while (k < 30 && !done) begin
         if (k == 4) check("result_held", result, last_res);
         if (glitch_cyc != 0 && k == glitch_cyc) begin
            start = 1'b1;
            a     = 8'hAA;
            b     = 8'h55;
            op    = OP_ADD;
         end else begin
            start = 1'b0;
         end
         tick();
         k++;
      end
      start = 1'b0;
      check("latency_cycles", k, 9);
      last_res = v.res;
      tick();
      check("busy_fall", busy, 0);
   endtask

   initial begin
      int k;
      int n0;
      tbl[0] = '{OP_ADD, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0};
      tbl[1] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
      tbl[2] = '{OP_SUB, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0};
      tbl[3] = '{OP_SUB, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0};
      tbl[4] = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
      tbl[5] = '{OP_OR,  8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0};
      tbl[6] = '{OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0};

      rst   = 1'b1;
      start = 1'b0;
      op    = OP_AND;
      a     = '0;
      b     = '0;
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_c_out", c_out, 0);
      check("rst_zero", zero, 1);
      rst = 1'b0;
      tick();

      // Row 4 (AND) also gets a stray start pulse in RUN cycle 3.
      for (int i = 0; i < 6; i++)
         run_op(tbl[i], (i == 4) ? 3 : 0);

      // Abort mid-run: reset sampled at the end of RUN cycle 4.
      wait_idle("wait_idle_rst");
      op    = OP_ADD;
      a     = 8'h33;
      b     = 8'h44;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 0);
      check("abort_zero", zero, 1);
      check("abort_c_out", c_out, 0);
      last_res = '0;
      n0 = n_done;
      for (int i = 0; i < 15; i++) tick();
      check("abort_no_done", n_done, n0);
      run_op(tbl[6], 0);

      // start held high: one accept every WIDTH+2 cycles.
      chk_gap       = 1'b1;
      last_done_cyc = -1;
      op            = OP_OR;
      a             = 8'h0F;
      b             = 8'hF0;
      start         = 1'b1;
      for (int n = 0; n < 3; n++) begin
         wait_idle("wait_idle_held");
         sb_q.push_back(tbl[5]);
         tick();
      end
      start = 1'b0;
      k = 0;
      while (sb_q.size() != 0 && k < 40) begin
         tick();
         k++;
      end
      check("held_outstanding", sb_q.size(), 0);
      check("held_done_count", n_done - n0, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
